// File: rtl/acc_pkg.sv
// Shared constants for the saturating accumulator bank: default widths,
// saturation rails at the default accumulator width, and the channel-index width rule.
package acc_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_NUM_CH = 4;

  localparam logic [DEF_ACC_W-1:0] SAT_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic [DEF_ACC_W-1:0] SAT_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

  // A single channel still needs a one-bit index so the port never collapses.
  function automatic int ch_width(input int numCh);
    return (numCh <= 2) ? 1 : $clog2(numCh);
  endfunction

endpackage

// File: rtl/acc_bank_sat_if.sv
// Term-input and result-output streams of the accumulator bank.
// The slave modport is the bank side; master is the producer/consumer side.
interface acc_bank_sat_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 16,
  parameter int CH_W   = 2
);

  logic              in_valid;
  logic              in_ready;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [ACC_W-1:0]  out_data;
  logic              out_sat;

  modport slave (
    input  in_valid, in_ch, in_data, in_last, out_ready,
    output in_ready, out_valid, out_ch, out_data, out_sat
  );

  modport master (
    output in_valid, in_ch, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_ch, out_data, out_sat
  );

endinterface

// File: rtl/acc_bank_sat_sat_add.sv
// Combinational saturating adder: accumulator plus sign-extended term,
// clamped to the signed ACC_W range, with a flag when clamping happened.
module sat_add
  import acc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [DATA_W-1:0] i_data,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_sat
);

  localparam logic [ACC_W-1:0] LMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] LMIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] w_wide;

  assign w_wide = {i_acc[ACC_W-1], i_acc}
                + {{(ACC_W+1-DATA_W){i_data[DATA_W-1]}}, i_data};

  // Top two bits disagreeing means the sum left the ACC_W range; bit ACC_W gives the direction.
  always_comb begin
    o_sum = w_wide[ACC_W-1:0];
    o_sat = 1'b0;
    if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
      o_sat = 1'b1;
      o_sum = w_wide[ACC_W] ? LMIN : LMAX;
    end
  end

endmodule

// File: rtl/acc_bank_sat.sv
// Multi-channel saturating accumulator bank with a single registered result stage.
// Optional ACC_BANK_RELU_EN: emitted results are clamped at zero (ReLU).
module acc_bank_sat
  import acc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  acc_bank_sat_if.slave  bus
);

  localparam int CH_W = ch_width(NUM_CH);

  logic [ACC_W-1:0] r_acc [NUM_CH];
  logic [NUM_CH-1:0] r_sticky;
  logic              r_outValid;
  logic [CH_W-1:0]   r_outCh;
  logic [ACC_W-1:0]  r_outData;
  logic              r_outSat;

  logic              w_inReady;
  logic              w_accept;
  logic              w_chOk;
  logic [ACC_W-1:0]  w_accSel;
  logic              w_stickySel;
  logic [ACC_W-1:0]  w_sum;
  logic              w_sat;
  logic [ACC_W-1:0]  w_resData;

  assign w_inReady = ~clr & (~r_outValid | bus.out_ready);
  assign w_accept  = bus.in_valid & w_inReady;
  assign w_chOk    = int'(bus.in_ch) < NUM_CH;

  // Out-of-range channels read as zero so no X leaks into the adder; their beats are dropped anyway.
  assign w_accSel    = w_chOk ? r_acc[bus.in_ch] : '0;
  assign w_stickySel = w_chOk ? r_sticky[bus.in_ch] : 1'b0;

  sat_add #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_satAdd (
    .i_acc  (w_accSel),
    .i_data (bus.in_data),
    .o_sum  (w_sum),
    .o_sat  (w_sat)
  );

`ifdef ACC_BANK_RELU_EN
  assign w_resData = w_sum[ACC_W-1] ? '0 : w_sum;
`else
  assign w_resData = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
      r_sticky <= '0;
    end else if (w_accept && w_chOk) begin
      if (bus.in_last) begin
        r_acc[bus.in_ch]    <= '0;
        r_sticky[bus.in_ch] <= 1'b0;
      end else begin
        r_acc[bus.in_ch]    <= w_sum;
        r_sticky[bus.in_ch] <= w_stickySel | w_sat;
      end
    end
  end

  // A last beat is only accepted when the stage is empty or being popped, so loading never overwrites a held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outValid <= 1'b0;
      r_outCh    <= '0;
      r_outData  <= '0;
      r_outSat   <= 1'b0;
    end else if (w_accept && w_chOk && bus.in_last) begin
      r_outValid <= 1'b1;
      r_outCh    <= bus.in_ch;
      r_outData  <= w_resData;
      r_outSat   <= w_stickySel | w_sat;
    end else if (r_outValid && bus.out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.out_ch    = r_outCh;
  assign bus.out_data  = r_outData;
  assign bus.out_sat   = r_outSat;

endmodule

// File: tb/tb_acc_bank_sat.sv
// Self-checking bench for acc_bank_sat at default parameters: a directed vector
// table with fully-ready output, then hand-written backpressure, reset and clr sequences.
module tb_acc_bank_sat;

  logic clk;
  logic reset;
  logic clr;

  acc_bank_sat_if #(.DATA_W(16), .ACC_W(16), .CH_W(2)) bus ();

  acc_bank_sat #(.DATA_W(16), .ACC_W(16), .NUM_CH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef ACC_BANK_RELU_EN
  localparam logic [15:0] NEG5_OUT = 16'h0000;
`else
  localparam logic [15:0] NEG5_OUT = 16'hFFFB;
`endif

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] data;
    logic        last;
    logic        expValid;
    logic [1:0]  expCh;
    logic [15:0] expData;
    logic        expSat;
  } vec_t;

  vec_t vecs [16];
  int   nApplied;
  int   nMiscompares;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nApplied++;
    if (act !== expv) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ch, input logic [15:0] data, input logic last);
    bus.in_valid = 1'b1;
    bus.in_ch    = ch;
    bus.in_data  = data;
    bus.in_last  = last;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResult(input string name, input logic [1:0] ch, input logic [15:0] data, input logic sat);
    checkOutput({name, " valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({name, " ch"},    32'(bus.out_ch),    32'(ch));
    checkOutput({name, " data"},  32'(bus.out_data),  32'(data));
    checkOutput({name, " sat"},   32'(bus.out_sat),   32'(sat));
  endtask

  initial begin
    nApplied     = 0;
    nMiscompares = 0;

    vecs[0]  = '{2'd0, 16'h7000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[1]  = '{2'd0, 16'h2000, 1'b1, 1'b1, 2'd0, 16'h7FFF, 1'b1};
    vecs[2]  = '{2'd3, 16'h8000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[3]  = '{2'd3, 16'hFFFF, 1'b1, 1'b1, 2'd3, 16'h8000, 1'b1};
    vecs[4]  = '{2'd3, 16'h0005, 1'b1, 1'b1, 2'd3, 16'h0005, 1'b0};
    vecs[5]  = '{2'd1, 16'h0003, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[6]  = '{2'd2, 16'hFFFB, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[7]  = '{2'd1, 16'h0004, 1'b1, 1'b1, 2'd1, 16'h0007, 1'b0};
    vecs[8]  = '{2'd2, 16'h0000, 1'b1, 1'b1, 2'd2, NEG5_OUT, 1'b0};
    vecs[9]  = '{2'd2, 16'hFFFB, 1'b1, 1'b1, 2'd2, NEG5_OUT, 1'b0};
    vecs[10] = '{2'd1, 16'h7FFF, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[11] = '{2'd1, 16'h0001, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[12] = '{2'd1, 16'hFFFE, 1'b1, 1'b1, 2'd1, 16'h7FFD, 1'b1};
    vecs[13] = '{2'd0, 16'h8000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0};
    vecs[14] = '{2'd0, 16'h8000, 1'b1, 1'b1, 2'd0, 16'h8000, 1'b1};
    vecs[15] = '{2'd2, 16'h0001, 1'b1, 1'b1, 2'd2, 16'h0001, 1'b0};

    reset         = 1'b1;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    // Reset state
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset out_ch",    32'(bus.out_ch),    32'd0);
    checkOutput("reset out_data",  32'(bus.out_data),  32'd0);
    checkOutput("reset out_sat",   32'(bus.out_sat),   32'd0);
    checkOutput("reset in_ready",  32'(bus.in_ready),  32'd1);

    // Table: one beat per cycle, consumer always ready
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].ch, vecs[i].data, vecs[i].last);
      #1;
      checkOutput($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].expValid));
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d out_ch", i),   32'(bus.out_ch),   32'(vecs[i].expCh));
        checkOutput($sformatf("vec%0d out_data", i), 32'(bus.out_data), 32'(vecs[i].expData));
        checkOutput($sformatf("vec%0d out_sat", i),  32'(bus.out_sat),  32'(vecs[i].expSat));
      end
    end
    bus.in_valid = 1'b0;
    stepCycle();
    checkOutput("drain out_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: result held, a pending last beat is not taken until the pop
    bus.out_ready = 1'b0;
    applyStimulus(2'd1, 16'h0001, 1'b1);
    stepCycle();
    checkResult("bp first", 2'd1, 16'h0001, 1'b0);
    applyStimulus(2'd0, 16'h0009, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp hold%0d in_ready", k), 32'(bus.in_ready), 32'd0);
      checkResult($sformatf("bp hold%0d", k), 2'd1, 16'h0001, 1'b0);
      stepCycle();
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("bp release in_ready", 32'(bus.in_ready), 32'd1);
    stepCycle();
    checkResult("bp second", 2'd0, 16'h0009, 1'b0);
    bus.in_valid = 1'b0;
    stepCycle();
    checkOutput("bp drain out_valid", 32'(bus.out_valid), 32'd0);

    // Reset mid-neuron discards the partial sum and drops a pending result
    applyStimulus(2'd0, 16'd100, 1'b0);
    stepCycle();
    bus.out_ready = 1'b0;
    applyStimulus(2'd1, 16'h0002, 1'b1);
    stepCycle();
    bus.in_valid = 1'b0;
    checkOutput("rst pending valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("rst drop out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst drop out_data",  32'(bus.out_data),  32'd0);
    checkOutput("rst drop out_ch",    32'(bus.out_ch),    32'd0);
    bus.out_ready = 1'b1;
    applyStimulus(2'd0, 16'h0005, 1'b1);
    stepCycle();
    checkResult("rst after", 2'd0, 16'h0005, 1'b0);
    bus.in_valid = 1'b0;
    stepCycle();

    // clr mid-neuron with a beat offered during the clr cycle
    applyStimulus(2'd0, 16'd100, 1'b0);
    stepCycle();
    clr = 1'b1;
    applyStimulus(2'd0, 16'h0005, 1'b1);
    #1;
    checkOutput("clr in_ready", 32'(bus.in_ready), 32'd0);
    stepCycle();
    clr = 1'b0;
    checkOutput("clr no take", 32'(bus.out_valid), 32'd0);
    stepCycle();
    checkResult("clr after", 2'd0, 16'h0005, 1'b0);
    bus.in_valid = 1'b0;
    stepCycle();

    // clr leaves a pending result untouched
    bus.out_ready = 1'b0;
    applyStimulus(2'd2, 16'h0007, 1'b1);
    stepCycle();
    bus.in_valid = 1'b0;
    clr = 1'b1;
    stepCycle();
    clr = 1'b0;
    checkResult("clr pending", 2'd2, 16'h0007, 1'b0);
    bus.out_ready = 1'b1;
    stepCycle();
    checkOutput("clr pending pop", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
    $finish;
  end

endmodule
